uart_rom_loader: RTL and testbench
==================================

# uart_rom_loader

Serial boot loader feeding the instruction ROM of the RISC-V SoC. Receives 8N1 UART bytes on `uart_rx`, assembles them little-endian into 32-bit instruction words, and issues one ROM write per word at incrementing byte addresses. It sits between the `uart_rx` pin and the ROM write port, and drives `loading` so the core is held idle while a program is streamed in.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 9600, UART bit rate; `BIT_CYC = CLK_FREQ/BAUD` (5208 at defaults, integer division)
- `ADDR_W`, 12, ROM byte-address width
- `TIMEOUT_CYC`, 1_000_000, idle cycles after last byte that end a load session

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_en`  in  1  loader enabled; low forces RX FSM to IDLE and clears session state
- `uart_rx`  in  1  asynchronous serial input, idle high
- `rom_we`  out  1  one-cycle ROM write strobe
- `rom_waddr`  out  ADDR_W  byte address of word being written (multiple of 4)
- `rom_wdata`  out  32  assembled instruction word
- `loading`  out  1  high from first valid byte of a session until session end
- `load_done`  out  1  one-cycle pulse at session end
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low

## Operation
- `uart_rx` passes a 2-flop synchronizer (reset value 1); all RX logic uses the synchronized copy `rx_s`.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_s` falling edge (prev 1, now 0) and `load_en` -> START, bit counter cleared.
  - START: at `BIT_CYC/2` cycles sample `rx_s`; 0 -> DATA, 1 (glitch) -> IDLE, no error.
  - DATA: sample every `BIT_CYC` cycles, LSB first, 8 bits -> STOP.
  - STOP: after `BIT_CYC` cycles sample; 1 -> byte valid; 0 -> `frame_err` pulse, byte discarded. Either way -> IDLE immediately (mid-stop), permitting back-to-back frames.
- Byte assembler: `byte_idx` 0..3; valid byte written to `word[8*byte_idx +: 8]`, `byte_idx` increments; on 4th byte `byte_idx` wraps to 0 and a write is issued.
- Write: `rom_wdata` = assembled word, `rom_waddr` = current `addr`; `addr` += 4 after the write, wrapping to 0 at 2^ADDR_W.
- Session: first valid byte sets `loading`. Idle counter restarts on every valid byte; reaching `TIMEOUT_CYC` while `loading` -> `load_done` pulse, `loading`=0, `addr`=0, `byte_idx`=0, partial word discarded.
- Frame error does not advance `byte_idx` or reset the idle counter.
- `load_en` deasserted mid-frame: FSM -> IDLE, `byte_idx`=0, `addr`=0, `loading`=0, no `load_done`, no write.
- `rom_waddr`/`rom_wdata` are held stable outside `rom_we`.

## Timing
- Reset values: `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0, `loading`=0, `load_done`=0, `frame_err`=0; FSM IDLE, `addr`=0, `byte_idx`=0.
- Synchronizer latency 2 cycles from pin to `rx_s`.
- Relative to falling-edge detect cycle T0: start check T0+`BIT_CYC/2`; data bit i at T0+`BIT_CYC/2`+(i+1)·`BIT_CYC`; stop at T0+`BIT_CYC/2`+9·`BIT_CYC`.
- Byte valid registered 1 cycle after stop sample; `loading` rises same cycle as first byte valid.
- `rom_we` asserted 1 cycle after 4th byte valid, exactly one cycle wide.
- `frame_err` asserted 1 cycle after a low stop sample.
- `load_done` asserted the cycle idle counter reaches `TIMEOUT_CYC`; `loading` falls same cycle.
- Timeout coinciding with a valid byte: byte wins, counter restarts, no `load_done`.

## Test plan
- Reset held, `uart_rx` toggling -> all outputs 0, no `rom_we`.
- Send 0x93,0x00,0x10,0x00 at 9600 baud -> single `rom_we` with `rom_waddr`=0x000, `rom_wdata`=0x00100093; `loading`=1 from first byte.
- Four words 0x00100093, 0x00200113, 0x001080B3, 0xFE208EE3 back-to-back -> writes at 0x0,0x4,0x8,0xC in order, then `load_done` after `TIMEOUT_CYC`, `loading`=0.
- Second byte sent with stop bit 0 -> `frame_err` pulse; next 4 good bytes 0x13,0x01,0x20,0x00 complete word 0x00200113 only after 3 further bytes (byte_idx unchanged by error).
- 1000-cycle low glitch on idle line -> START rejects, no byte, no `frame_err`.
- `ADDR_W`=4, 5 words -> addresses 0x0,0x4,0x8,0xC,0x0; `load_en` dropped mid-byte -> no write, `loading`=0, next session starts at 0x0.

Source files
------------

// File: rtl/uart_rom_loader.sv
// -----------------------------------------------------------------------------
// uart_rom_loader
//
// Serial boot loader for the instruction ROM. It receives 8N1 UART bytes on
// uart_rx and assembles them little-endian into 32-bit words. It writes each
// completed word to the ROM at an incrementing byte address. While a program
// is streaming in, it holds `loading` high so the core stays idle.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   BAUD         UART bit rate; one bit lasts CLK_FREQ/BAUD cycles
//   ADDR_W       ROM byte-address width
//   TIMEOUT_CYC  idle cycles after the last good byte that close a session
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   load_en    in   loader enable; low aborts the frame and the session
//   uart_rx    in   asynchronous serial input, idle high
//   rom_we     out  one-cycle ROM write strobe
//   rom_waddr  out  byte address of the word being written (multiple of 4)
//   rom_wdata  out  assembled instruction word
//   loading    out  high from the first good byte until the session ends
//   load_done  out  one-cycle pulse when a session times out
//   frame_err  out  one-cycle pulse when a stop bit samples low
// -----------------------------------------------------------------------------
module uart_rom_loader #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              loading,
    output logic              load_done,
    output logic              frame_err
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_e;

    // Input synchronizer and edge history.
    logic sync1_q, rx_s_q, rx_prev_q;

    // Receive FSM.
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_ok, byte_bad;

    // Word assembly, session tracking and the ROM write port.
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_pend_q, wr_pend_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              loading_q, loading_d;
    logic              load_done_q, load_done_d;
    logic              frame_err_q, frame_err_d;

    // The synchronizer resets to the idle-high line level, so leaving reset
    // never looks like a start-bit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every flop
            // then samples the values from before the edge, so the
            // synchronizer chain really is three distinct stages.
            sync1_q   <= uart_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM: next state and sample strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the case
        // statement. A path that forgets to assign one would otherwise infer a
        // latch.
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (load_en && rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                end
            end
            S_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Return to IDLE at mid stop bit so a back-to-back start edge
                // is not missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    byte_ok  = rx_s_q;
                    byte_bad = !rx_s_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!load_en) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            byte_ok  = 1'b0;
            byte_bad = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // -------------------------------------------------------------------------
    // Word assembly, session timeout and ROM write
    // -------------------------------------------------------------------------
    always_comb begin
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wr_pend_d   = 1'b0;
        idle_cnt_d  = loading_q ? idle_cnt_q + IDLE_W'(1) : idle_cnt_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        loading_d   = loading_q;
        load_done_d = 1'b0;
        frame_err_d = byte_bad;

        // The word completed by the previous byte goes out one cycle later.
        // Outside this strobe, the address and data outputs hold their values.
        if (wr_pend_q) begin
            rom_we_d    = 1'b1;
            rom_waddr_d = addr_q;
            rom_wdata_d = word_q;
            addr_d      = addr_q + ADDR_W'(4);
        end

        // A byte that arrives in the timeout cycle wins. A frame error touches
        // neither the byte index nor the idle counter.
        if (byte_ok) begin
            word_d[8*byte_idx_q +: 8] = shift_q;
            byte_idx_d = byte_idx_q + 2'd1;
            wr_pend_d  = (byte_idx_q == 2'd3);
            loading_d  = 1'b1;
            idle_cnt_d = '0;
        end else if (loading_q && idle_cnt_q == IDLE_LAST) begin
            load_done_d = 1'b1;
            loading_d   = 1'b0;
            addr_d      = '0;
            byte_idx_d  = '0;
        end

        // An abort closes the session silently and discards any partial word.
        if (!load_en) begin
            byte_idx_d  = '0;
            addr_d      = '0;
            wr_pend_d   = 1'b0;
            idle_cnt_d  = '0;
            rom_we_d    = 1'b0;
            rom_waddr_d = rom_waddr_q;
            rom_wdata_d = rom_wdata_q;
            loading_d   = 1'b0;
            load_done_d = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            wr_pend_q   <= 1'b0;
            idle_cnt_q  <= '0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
            loading_q   <= 1'b0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            wr_pend_q   <= wr_pend_d;
            idle_cnt_q  <= idle_cnt_d;
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            loading_q   <= loading_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign loading   = loading_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_rom_loader
//
// Directed and randomized byte streams for uart_rom_loader, run at a reduced
// bit period and timeout. Expected ROM writes come from a byte-queue model:
// every four good bytes form one little-endian word, written at the next
// multiple of 4 modulo 2^ADDR_W. The end of a session discards leftover bytes
// and restarts the address at 0.
// -----------------------------------------------------------------------------
module tb_uart_rom_loader;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_FREQ / BAUD;   // 16 clocks per bit
    localparam int AW       = 4;
    localparam int TO       = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic          uart_rx = 1'b1;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          loading;
    logic          load_done;
    logic          frame_err;

    always #5 clk = ~clk;

    uart_rom_loader #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .uart_rx  (uart_rx),
        .rom_we   (rom_we),
        .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata),
        .loading  (loading),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;

    // Observed write log and event counters, sampled on the falling edge.
    logic [AW+31:0] obs_wr[$];
    int             fe_cnt    = 0;
    int             ld_cnt    = 0;
    int             stab_viol = 0;
    logic [AW-1:0]  prev_addr = '0;
    logic [31:0]    prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_we) obs_wr.push_back({rom_waddr, rom_wdata});
            else if (rom_waddr !== prev_addr || rom_wdata !== prev_data) stab_viol++;
            if (frame_err) fe_cnt++;
            if (load_done) ld_cnt++;
        end
        prev_addr = rom_waddr;
        prev_data = rom_wdata;
    end

    // Reference model.
    logic [AW+31:0] exp_wr[$];
    logic [7:0]     pend[$];
    logic [AW-1:0]  m_addr = '0;

    task automatic model_byte(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == 4) begin
            exp_wr.push_back({m_addr, pend[3], pend[2], pend[1], pend[0]});
            m_addr = AW'((int'(m_addr) + 4) % (1 << AW));
            pend.delete();
        end
    endtask

    task automatic model_end();
        pend.delete();
        m_addr = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame from a falling edge. If drop_bit names a data bit,
    // load_en is released halfway through that bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int drop_bit);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            if (i == drop_bit) begin
                repeat (BIT / 2) @(negedge clk);
                load_en = 1'b0;
                repeat (BIT - BIT / 2) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        uart_rx = stop_bit;
        repeat (BIT) @(negedge clk);
        if (!stop_bit) begin
            uart_rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1, -1);
        model_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_good(w[8*k +: 8]);
    endtask

    task automatic check_writes(input string tag);
        int n;
        repeat (4) @(negedge clk);
        check($sformatf("%s_count", tag), 64'(obs_wr.size()), 64'(exp_wr.size()));
        n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(obs_wr[i]), 64'(exp_wr[i]));
        obs_wr.delete();
        exp_wr.delete();
    endtask

    // Called right after the last byte of a loading session.
    task automatic wait_timeout(input string tag);
        int ld0;
        int waited;
        ld0    = ld_cnt;
        waited = 0;
        repeat (TO - 200) @(negedge clk);
        check($sformatf("%s_early", tag), 64'(ld_cnt - ld0), 64'd0);
        check($sformatf("%s_still_loading", tag), 64'(loading), 64'd1);
        while (ld_cnt == ld0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        check($sformatf("%s_done", tag), 64'(ld_cnt - ld0), 64'd1);
        check($sformatf("%s_loading_low", tag), 64'(loading), 64'd0);
        model_end();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fe0;
        int ld0;
        int n;
        logic [7:0] rb;

        // Reset held while the line toggles: every output stays at zero.
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            uart_rx = 1'($urandom_range(0, 1));
            load_en = 1'($urandom_range(0, 1));
        end
        check("rst_rom_we",    64'(rom_we),    64'd0);
        check("rst_rom_waddr", 64'(rom_waddr), 64'd0);
        check("rst_rom_wdata", 64'(rom_wdata), 64'd0);
        check("rst_loading",   64'(loading),   64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        uart_rx = 1'b1;
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_write", 64'(obs_wr.size()), 64'd0);

        // Single word; loading rises with the first byte.
        check("t1_loading_before", 64'(loading), 64'd0);
        send_good(8'h93);
        check("t1_loading_first", 64'(loading), 64'd1);
        send_good(8'h00);
        send_good(8'h10);
        send_good(8'h00);
        check_writes("t1");
        wait_timeout("t1_to");

        // Four back-to-back words, then a timeout.
        send_word(32'h0010_0093);
        send_word(32'h0020_0113);
        send_word(32'h0010_80B3);
        send_word(32'hFE20_8EE3);
        check_writes("t2");
        wait_timeout("t2_to");

        // A frame error does not advance the byte position.
        fe0 = fe_cnt;
        send_good(8'h13);
        send_byte(8'hA5, 1'b0, -1);
        check("fe_pulse", 64'(fe_cnt - fe0), 64'd1);
        send_good(8'h01);
        send_good(8'h20);
        check("fe_no_early_write", 64'(obs_wr.size()), 64'd0);
        send_good(8'h00);
        check_writes("fe");
        wait_timeout("fe_to");

        // A short low glitch is rejected at the start-bit check.
        fe0 = fe_cnt;
        ld0 = ld_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("gl_no_fe",      64'(fe_cnt - fe0),  64'd0);
        check("gl_no_loading", 64'(loading),       64'd0);
        check("gl_no_write",   64'(obs_wr.size()), 64'd0);
        check("gl_no_done",    64'(ld_cnt - ld0),  64'd0);

        // Five random words: the address wraps at 2^AW.
        for (int w = 0; w < 5; w++) send_word($urandom);
        check_writes("wrap");
        wait_timeout("wrap_to");

        // load_en released mid-byte ends the session without a write or load_done.
        ld0 = ld_cnt;
        send_word($urandom);
        send_good(8'($urandom));
        send_good(8'($urandom));
        send_byte(8'($urandom), 1'b1, 3);
        model_end();
        repeat (2) @(negedge clk);
        check("drop_loading", 64'(loading), 64'd0);
        check_writes("drop");
        repeat (TO + 100) @(negedge clk);
        check("drop_no_done", 64'(ld_cnt - ld0), 64'd0);
        load_en = 1'b1;
        repeat (BIT) @(negedge clk);
        send_word($urandom);
        check_writes("drop_next");
        wait_timeout("drop_to");

        // A random-length session leaves a partial word that the timeout discards.
        n = int'($urandom_range(5, 11));
        for (int i = 0; i < n; i++) begin
            rb = 8'($urandom);
            send_good(rb);
        end
        check_writes("rnd");
        wait_timeout("rnd_to");
        send_word($urandom);
        check_writes("rnd_next");
        wait_timeout("rnd_next_to");

        check("total_frame_err", 64'(fe_cnt), 64'd1);
        check("addr_data_stable", 64'(stab_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
